pc_unit: RTL and testbench

//  Parametrised program-counter unit; successor to the single-register PC latch.

---
 rtl/pc_unit_pkg.sv | 18 +
 rtl/pc_unit_if.sv | 35 +++
 rtl/pc_ras.sv | 55 +++++
 rtl/pc_unit.sv | 134 +++++++++++++
 tb/tb_pc_unit.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and default constants for the program-counter unit.
//   pcu_state_e    - FSM state encoding {BOOT, RUN, HALT}
//   PCU_ADDR_W     - default PC width
//   PCU_RESET_VEC  - default reset vector
//   PCU_INC        - default sequential increment
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } pcu_state_e;

  localparam int unsigned PCU_ADDR_W    = 15;
  localparam int unsigned PCU_RESET_VEC = 0;
  localparam int unsigned PCU_INC       = 1;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/address bundle between the fetch controller and pc_unit.
//   master: drives PCWrite, branch_taken, branch_target, call_req, ret_req,
//           halt_req, resume_req; observes pcaddout, pc_valid, halted, ras_err.
//   slave : the pc_unit side (directions reversed).
interface pc_unit_if
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = PCU_ADDR_W
) ();

  logic              PCWrite;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              call_req;
  logic              ret_req;
  logic              halt_req;
  logic              resume_req;
  logic [ADDR_W-1:0] pcaddout;
  logic              pc_valid;
  logic              halted;
  logic              ras_err;

  modport master (
    output PCWrite, branch_taken, branch_target, call_req, ret_req,
           halt_req, resume_req,
    input  pcaddout, pc_valid, halted, ras_err
  );

  modport slave (
    input  PCWrite, branch_taken, branch_target, call_req, ret_req,
           halt_req, resume_req,
    output pcaddout, pc_valid, halted, ras_err
  );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: DEPTH x ADDR_W circular return-address stack.
//   clk, Resetzero : clock, synchronous active-high reset (empties the stack)
//   push, push_data: write push_data on top; when full the oldest entry is lost
//   pop            : discard top entry (ignored when empty)
//   top            : current top entry
//   full, empty    : occupancy flags
module pc_ras #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              Resetzero,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     sp_q;   // next free slot
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     sp_inc, sp_dec;

  // Explicit wrap so non-power-of-two depths stay circular.
  assign sp_inc = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + 1'b1;
  assign sp_dec = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - 1'b1;

  assign top   = mem_q[sp_dec];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (Resetzero) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (push) begin
      sp_q <= sp_inc;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q  <= sp_dec;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (!Resetzero && push) mem_q[sp_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter unit at the head of the fetch stage.
//   clk        : rising-edge clock
//   Resetzero  : synchronous active-high reset
//   bus (slave): PCWrite, branch_taken, branch_target, call_req, ret_req,
//                halt_req, resume_req in; pcaddout, pc_valid, halted, ras_err out
// Optional feature: define PCU_RAS_EN to build the return-address stack;
// without it call_req behaves as a branch and ret_req as an RAS underflow.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W    = PCU_ADDR_W,
  parameter int unsigned RESET_VEC = PCU_RESET_VEC,
  parameter int unsigned INC       = PCU_INC,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     Resetzero,
  pc_unit_if.slave bus
);

  pcu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_seq;

  // Modulo 2^ADDR_W by truncation; wrap is silent.
  assign pc_seq = pc_q + ADDR_W'(INC);

`ifdef PCU_RAS_EN
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .Resetzero (Resetzero),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    err_d    = 1'b0;
`ifdef PCU_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    case (state_q)
      // Leaving BOOT advances like a plain RUN step so the first valid
      // address follows the reset vector; redirects are not yet honoured.
      BOOT: begin
        state_d  = RUN;
        valid_d  = 1'b1;
        halted_d = 1'b0;
        if (bus.PCWrite) pc_d = pc_seq;
      end
      RUN: begin
        if (bus.halt_req) begin
          state_d  = HALT;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end else if (bus.call_req && bus.ret_req) begin
          err_d = 1'b1;
          if (bus.PCWrite) pc_d = pc_seq;
        end else if (bus.ret_req) begin
`ifdef PCU_RAS_EN
          if (ras_empty) begin
            pc_d  = pc_seq;
            err_d = 1'b1;
          end else begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end
`else
          pc_d  = pc_seq;
          err_d = 1'b1;
`endif
        end else if (bus.call_req) begin
          pc_d = bus.branch_target;
`ifdef PCU_RAS_EN
          ras_push = 1'b1;
          err_d    = ras_full;
`endif
        end else if (bus.branch_taken) begin
          pc_d = bus.branch_target;
        end else if (bus.PCWrite) begin
          pc_d = pc_seq;
        end
      end
      HALT: begin
        if (bus.resume_req) begin
          state_d  = RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Resetzero) begin
      state_q  <= BOOT;
      pc_q     <= ADDR_W'(RESET_VEC);
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign bus.pcaddout = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.halted   = halted_q;
  assign bus.ras_err  = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (ADDR_W=15, RESET_VEC=0,
// INC=1, RAS_DEPTH=4). RAS-specific steps are selected by PCU_RAS_EN.
module tb_pc_unit;

  logic clk = 1'b0;
  logic Resetzero;
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_unit_if #(.ADDR_W(15)) bus ();

  pc_unit #(
    .ADDR_W    (15),
    .RESET_VEC (0),
    .INC       (1),
    .RAS_DEPTH (4)
  ) dut (
    .clk       (clk),
    .Resetzero (Resetzero),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic v,
                         input logic h, input logic e);
    chk({tag, ".pc"},     32'(bus.pcaddout), pc);
    chk({tag, ".valid"},  32'(bus.pc_valid), 32'(v));
    chk({tag, ".halted"}, 32'(bus.halted),   32'(h));
    chk({tag, ".err"},    32'(bus.ras_err),  32'(e));
  endtask

  // One clock edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.branch_taken = 1'b0;
    bus.call_req     = 1'b0;
    bus.ret_req      = 1'b0;
    bus.halt_req     = 1'b0;
    bus.resume_req   = 1'b0;
  endtask

  initial begin
    Resetzero         = 1'b1;
    bus.PCWrite       = 1'b1;
    bus.branch_target = '0;
    idle();

    // Reset for two cycles, release; BOOT cycle shows reset vector, invalid
    step(); step();
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    Resetzero = 1'b0;
    chk_all("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("seq1", 32'h1, 1'b1, 1'b0, 1'b0);
    step(); chk_all("seq2", 32'h2, 1'b1, 1'b0, 1'b0);
    step(); chk_all("seq3", 32'h3, 1'b1, 1'b0, 1'b0);
    step(); step(); chk("seq5", 32'(bus.pcaddout), 32'h5);

    // Stall three cycles, then resume
    bus.PCWrite = 1'b0;
    step(); chk("stall1", 32'(bus.pcaddout), 32'h5);
    step(); chk("stall2", 32'(bus.pcaddout), 32'h5);
    step(); chk("stall3", 32'(bus.pcaddout), 32'h5);
    bus.PCWrite = 1'b1;
    step(); chk("unstall", 32'(bus.pcaddout), 32'h6);

    // Branch, and branch overriding a stall
    bus.branch_taken = 1'b1; bus.branch_target = 15'h100;
    step(); chk_all("branch", 32'h100, 1'b1, 1'b0, 1'b0);
    bus.branch_taken = 1'b0;
    step(); chk("after_branch", 32'(bus.pcaddout), 32'h101);
    bus.PCWrite = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 15'h200;
    step(); chk("branch_in_stall", 32'(bus.pcaddout), 32'h200);
    bus.PCWrite = 1'b1; bus.branch_taken = 1'b0;

    // Wrap at all-ones address
    bus.branch_taken = 1'b1; bus.branch_target = 15'h7FFF;
    step(); chk("to_max", 32'(bus.pcaddout), 32'h7FFF);
    bus.branch_taken = 1'b0;
    step(); chk_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // Halt / resume at 0x20; branch during HALT ignored
    bus.branch_taken = 1'b1; bus.branch_target = 15'h20;
    step(); chk("to_20", 32'(bus.pcaddout), 32'h20);
    bus.branch_taken = 1'b0; bus.halt_req = 1'b1;
    step(); chk_all("halt", 32'h20, 1'b0, 1'b1, 1'b0);
    bus.halt_req = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 15'h300;
    step(); chk_all("halt_branch", 32'h20, 1'b0, 1'b1, 1'b0);
    bus.branch_taken = 1'b0; bus.resume_req = 1'b1;
    step(); chk_all("resume", 32'h20, 1'b1, 1'b0, 1'b0);
    bus.resume_req = 1'b0;
    step(); chk_all("post_resume", 32'h21, 1'b1, 1'b0, 1'b0);

    // call+ret conflict: advance (or hold under stall), error pulse
    bus.call_req = 1'b1; bus.ret_req = 1'b1; bus.branch_target = 15'h400;
    step(); chk_all("conflict", 32'h22, 1'b1, 1'b0, 1'b1);
    idle();
    step(); chk_all("conflict_clr", 32'h23, 1'b1, 1'b0, 1'b0);
    bus.call_req = 1'b1; bus.ret_req = 1'b1; bus.PCWrite = 1'b0;
    step(); chk_all("conflict_stall", 32'h23, 1'b1, 1'b0, 1'b1);
    idle(); bus.PCWrite = 1'b1;

`ifdef PCU_RAS_EN
    // Call 0x40 from 0x10, return at 0x42 -> 0x11
    bus.branch_taken = 1'b1; bus.branch_target = 15'h10;
    step(); chk("to_10", 32'(bus.pcaddout), 32'h10);
    bus.branch_taken = 1'b0; bus.call_req = 1'b1; bus.branch_target = 15'h40;
    step(); chk_all("call", 32'h40, 1'b1, 1'b0, 1'b0);
    bus.call_req = 1'b0;
    step(); step(); chk("at_42", 32'(bus.pcaddout), 32'h42);
    bus.ret_req = 1'b1;
    step(); chk_all("ret", 32'h11, 1'b1, 1'b0, 1'b0);
    bus.ret_req = 1'b0;

    // Five calls into a 4-deep stack: pushes 0x12,0x51,0x61,0x71,0x81
    bus.call_req = 1'b1;
    bus.branch_target = 15'h50; step(); chk_all("call1", 32'h50, 1'b1, 1'b0, 1'b0);
    bus.branch_target = 15'h60; step(); chk_all("call2", 32'h60, 1'b1, 1'b0, 1'b0);
    bus.branch_target = 15'h70; step(); chk_all("call3", 32'h70, 1'b1, 1'b0, 1'b0);
    bus.branch_target = 15'h80; step(); chk_all("call4", 32'h80, 1'b1, 1'b0, 1'b0);
    bus.branch_target = 15'h90; step(); chk_all("call5_ovf", 32'h90, 1'b1, 1'b0, 1'b1);
    bus.call_req = 1'b0;

    // Five returns: 0x81,0x71,0x61,0x51 then underflow from 0x51 -> 0x52
    bus.ret_req = 1'b1;
    step(); chk_all("ret1", 32'h81, 1'b1, 1'b0, 1'b0);
    step(); chk_all("ret2", 32'h71, 1'b1, 1'b0, 1'b0);
    step(); chk_all("ret3", 32'h61, 1'b1, 1'b0, 1'b0);
    step(); chk_all("ret4", 32'h51, 1'b1, 1'b0, 1'b0);
    step(); chk_all("ret5_unf", 32'h52, 1'b1, 1'b0, 1'b1);
    bus.ret_req = 1'b0;
    step(); chk_all("ret_clr", 32'h53, 1'b1, 1'b0, 1'b0);
`else
    // No RAS: ret is underflow, call is a plain branch (no push)
    bus.ret_req = 1'b1;
    step(); chk_all("ret_norm", 32'h24, 1'b1, 1'b0, 1'b1);
    bus.ret_req = 1'b0; bus.call_req = 1'b1; bus.branch_target = 15'h40;
    step(); chk_all("call_norm", 32'h40, 1'b1, 1'b0, 1'b0);
    bus.call_req = 1'b0; bus.ret_req = 1'b1;
    step(); chk_all("ret_after_call", 32'h41, 1'b1, 1'b0, 1'b1);
    bus.ret_req = 1'b0;
`endif

    // Push one entry, halt, then reset with a simultaneous call
    bus.call_req = 1'b1; bus.branch_target = 15'h600;
    step(); chk("pre_halt_call", 32'(bus.pcaddout), 32'h600);
    bus.call_req = 1'b0; bus.halt_req = 1'b1;
    step(); chk_all("halt2", 32'h600, 1'b0, 1'b1, 1'b0);
    bus.halt_req = 1'b0; bus.call_req = 1'b1; Resetzero = 1'b1;
    step(); chk_all("reset_in_halt", 32'h0, 1'b0, 1'b0, 1'b0);
    bus.call_req = 1'b0; Resetzero = 1'b0;
    step(); chk_all("reboot", 32'h1, 1'b1, 1'b0, 1'b0);
    // RAS emptied by reset: ret underflows (same result without RAS)
    bus.ret_req = 1'b1;
    step(); chk_all("ret_after_reset", 32'h2, 1'b1, 1'b0, 1'b1);
    bus.ret_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
